// File: rtl/led_pwm_driver.sv
// LED PWM output stage: 15-tick PWM per LED with duty slewing one step every RAMP_PERIODS periods.
// Enables and targets are sampled only on the period boundary; led is registered (1 clk latency).
module led_pwm_driver #(
   parameter int PRESCALE     = 4,
   parameter int RAMP_PERIODS = 8,
   parameter bit INVERT       = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:1] vec,
   input  logic [4:1]  pwm [1:2],
   output logic [12:1] led,
   output logic        period_start,
   output logic [4:1]  duty1,
   output logic [4:1]  duty2
);

   localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int            RW        = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
   localparam logic [RW-1:0] RC_MAX    = RW'(RAMP_PERIODS - 1);
   localparam logic [3:0]    PHASE_MAX = 4'd14;

   logic [PW-1:0] pre;
   logic [3:0]    phase;
   logic [RW-1:0] rc;
   logic [3:0]    cur1;
   logic [3:0]    cur2;
   logic [12:1]   vec_sh;
   logic [12:1]   raw;
   logic          tick;
   logic          boundary;
   logic          rc_wrap;
   logic          lit1;
   logic          lit2;

   assign tick     = (pre == PRE_MAX);
   assign boundary = tick && (phase == PHASE_MAX);
   assign rc_wrap  = (rc == RC_MAX);

   // One step toward the target; never overshoots because equality holds.
   function automatic logic [3:0] slew(input logic [3:0] c, input logic [3:0] t);
      if (c < t)
         return c + 4'd1;
      else if (c > t)
         return c - 4'd1;
      else
         return c;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre   <= '0;
         phase <= '0;
      end else if (tick) begin
         pre   <= '0;
         phase <= (phase == PHASE_MAX) ? 4'd0 : phase + 4'd1;
      end else begin
         pre   <= pre + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rc     <= '0;
         cur1   <= '0;
         cur2   <= '0;
         vec_sh <= '0;
      end else if (boundary) begin
         vec_sh <= vec;
         rc     <= rc_wrap ? '0 : rc + RW'(1);
         if (rc_wrap) begin
            cur1 <= slew(cur1, pwm[1]);
            cur2 <= slew(cur2, pwm[2]);
         end
      end
   end

   // cur = 15 exceeds every phase value, so the LED stays lit all period.
   assign lit1 = (phase < cur1);
   assign lit2 = (phase < cur2);
   assign raw  = vec_sh & {{6{lit2}}, {6{lit1}}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led          <= {12{INVERT}};
         period_start <= 1'b0;
      end else begin
         led          <= INVERT ? ~raw : raw;
         period_start <= boundary;
      end
   end

   assign duty1 = cur1;
   assign duty2 = cur2;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: two instances (fast ramp / slow inverted ramp) against a cycle-count model.
module tb_led_pwm_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:1] vec;
   logic [4:1]  pwm [1:2];

   logic [12:1] led_a, led_b;
   logic        ps_a, ps_b;
   logic [4:1]  d1_a, d2_a, d1_b, d2_b;

   int checks = 0;
   int passed = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   led_pwm_driver #(.PRESCALE(4), .RAMP_PERIODS(1), .INVERT(1'b0)) dut_a (
      .clk(clk), .reset(reset), .vec(vec), .pwm(pwm),
      .led(led_a), .period_start(ps_a), .duty1(d1_a), .duty2(d2_a)
   );

   led_pwm_driver #(.PRESCALE(4), .RAMP_PERIODS(8), .INVERT(1'b1)) dut_b (
      .clk(clk), .reset(reset), .vec(vec), .pwm(pwm),
      .led(led_b), .period_start(ps_b), .duty1(d1_b), .duty2(d2_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: state derived from the number of clk edges since reset release.
   int          mp   [2] = '{4, 4};
   int          mr   [2] = '{1, 8};
   bit          minv [2] = '{1'b0, 1'b1};
   int          k    [2];
   int          per  [2];
   int          cur  [2][2];
   logic [12:1] vsh  [2];
   logic [12:1] mled [2];
   logic        mps  [2];

   function automatic int toward(input int c, input int t);
      if (c < t) return c + 1;
      if (c > t) return c - 1;
      return c;
   endfunction

   always @(posedge clk or posedge reset) begin
      int ph, kn, plen;
      logic [12:1] r;
      if (reset) begin
         for (int j = 0; j < 2; j++) begin
            k[j] <= 0; per[j] <= 0; cur[j][0] <= 0; cur[j][1] <= 0;
            vsh[j] <= '0; mps[j] <= 1'b0;
            mled[j] <= minv[j] ? 12'hFFF : 12'h000;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            plen = 15 * mp[j];
            ph = (k[j] / mp[j]) % 15;
            for (int i = 1; i <= 12; i++)
               r[i] = vsh[j][i] && (ph < cur[j][(i <= 6) ? 0 : 1]);
            mled[j] <= minv[j] ? ~r : r;
            kn = k[j] + 1;
            k[j] <= kn;
            mps[j] <= (kn % plen == 0);
            if (kn % plen == 0) begin
               vsh[j] <= vec;
               per[j] <= per[j] + 1;
               if ((per[j] + 1) % mr[j] == 0) begin
                  cur[j][0] <= toward(cur[j][0], int'(pwm[1]));
                  cur[j][1] <= toward(cur[j][1], int'(pwm[2]));
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("led_a",   led_a, mled[0]);
         check("ps_a",    ps_a,  mps[0]);
         check("duty1_a", d1_a,  cur[0][0]);
         check("duty2_a", d2_a,  cur[0][1]);
         check("led_b",   led_b, mled[1]);
         check("ps_b",    ps_b,  mps[1]);
         check("duty1_b", d1_b,  cur[1][0]);
         check("duty2_b", d2_b,  cur[1][1]);
      end
   end

   task automatic wait_ps(input int n);
      for (int p = 0; p < n; p++) begin
         bit seen = 1'b0;
         for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (ps_a) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) begin
            check("period_start_timeout", 0, 1);
            return;
         end
      end
   endtask

   task automatic count_to_ps(output int n);
      n = -1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (ps_a) begin
            n = c;
            break;
         end
      end
   endtask

   initial begin
      int n, hi, first, other, bad;
      bit reached;
      reset  = 1'b1;
      vec    = 12'h000;
      pwm[1] = 4'd0;
      pwm[2] = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_led_a", led_a, 12'h000);
      check("rst_led_b", led_b, 12'hFFF);
      check("rst_ps_a", ps_a, 0);
      check("rst_duty1_a", d1_a, 0);
      check("rst_duty2_a", d2_a, 0);
      cmp_en = 1'b1;

      // Ramp-up at one step per period.
      vec    = 12'hFFF;
      pwm[1] = 4'd15;
      pwm[2] = 4'd15;
      reset  = 1'b0;
      count_to_ps(n);
      check("first_ps_delay", n, 60);
      check("ramp_duty1_1", d1_a, 1);
      wait_ps(4);
      check("ramp_duty1_5", d1_a, 5);
      wait_ps(10);
      check("ramp_duty1_15", d1_a, 15);
      wait_ps(1);
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         if (led_a !== 12'hFFF) bad++;
         @(negedge clk);
      end
      check("full_on_steady", bad, 0);

      // Steady duty 5 on LED 1 only.
      pwm[1] = 4'd5;
      vec    = 12'h001;
      wait_ps(12);
      hi = 0; first = -1; other = 0;
      for (int c = 0; c < 60; c++) begin
         if (led_a[1] === 1'b1) begin
            hi++;
            if (first < 0) first = c;
         end
         if (led_a[12:2] !== 11'h0) other++;
         if (c < 59) @(negedge clk);
      end
      check("duty5_high_clks", hi, 20);
      check("duty5_first_high", first, 1);
      check("duty5_others_low", other, 0);

      // Mid-period enable change is held off until the next boundary.
      vec = 12'h000;
      wait_ps(1);
      repeat (28) @(negedge clk);
      vec = 12'hFFF;
      bad = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (led_a !== 12'h000) bad++;
         if (ps_a) break;
      end
      check("midvec_held", bad, 0);
      @(negedge clk);
      check("midvec_applied", led_a, 12'hFFF);

      // Slow ramp on the inverted instance: wait for 15, then slew down to 3.
      reached = 1'b0;
      for (int p = 0; p < 140; p++) begin
         if (d2_b === 4'd15) begin
            reached = 1'b1;
            break;
         end
         wait_ps(1);
      end
      check("rampb_reached15", reached, 1);
      pwm[2] = 4'd3;
      wait_ps(7);
      check("rampb_hold_7", d2_b, 15);
      wait_ps(1);
      check("rampb_step_8", d2_b, 14);
      wait_ps(87);
      check("rampb_95", d2_b, 4);
      wait_ps(1);
      check("rampb_96", d2_b, 3);
      wait_ps(16);
      check("rampb_no_overshoot", d2_b, 3);

      // Asynchronous reset in the middle of a lit pulse.
      repeat (10) @(negedge clk);
      check("pre_reset_led_a", led_a, 12'hFFF);
      #2;
      reset = 1'b1;
      #1;
      check("async_led_a", led_a, 12'h000);
      check("async_led_b", led_b, 12'hFFF);
      check("async_duty1_a", d1_a, 0);
      check("async_ps_a", ps_a, 0);
      @(negedge clk);
      reset = 1'b0;
      count_to_ps(n);
      check("restart_ps_delay", n, 60);
      check("restart_duty1_a", d1_a, 1);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
